mmu_login_ctrl: RTL and testbench

Session controller that sits directly upstream of the MMU and drives its `login` input. It snoops the processor-to-memory bus for a three-word unlock sequence stored to a dedicated key address and, when the sequence is correct, holds `login` high for a session. Wrong keys are counted, and repeated failures lock the controller out for a fixed period. The `login` output connects straight to the MMU's `login` port.

---
 rtl/mmu_login_ctrl_pkg.sv | 22 ++
 rtl/mmu_login_ctrl_timer.sv | 46 ++++
 rtl/mmu_login_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mmu_login_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mmu_login_ctrl_pkg.sv
// mmu_login_ctrl_pkg
//   Shared encodings for the MMU login session controller.
//   - Bus command encodings (BUS_NONE / BUS_LOAD / BUS_STORE), matching the
//     processor-to-memory bus.
//   - 3-bit login FSM state encodings (LOGIN_IDLE .. LOGIN_LOCKOUT).
//   - Widths of the session/lockout timer and the wrong-key counter.
package mmu_login_ctrl_pkg;

    localparam logic [1:0] BUS_NONE  = 2'h0;
    localparam logic [1:0] BUS_LOAD  = 2'h1;
    localparam logic [1:0] BUS_STORE = 2'h2;

    localparam logic [2:0] LOGIN_IDLE    = 3'd0;
    localparam logic [2:0] LOGIN_GOT0    = 3'd1;
    localparam logic [2:0] LOGIN_GOT1    = 3'd2;
    localparam logic [2:0] LOGIN_SESSION = 3'd3;
    localparam logic [2:0] LOGIN_LOCKOUT = 3'd4;

    localparam int TIMER_W = 11;
    localparam int FAIL_W  = 2;

endpackage

// File: rtl/mmu_login_ctrl_timer.sv
// login_timer
//   Loadable down-counter that stops at zero (never wraps). One instance is
//   shared by the SESSION and LOCKOUT states of mmu_login_ctrl.
// Ports:
//   clock     in  1        rising-edge clock
//   reset_n   in  1        synchronous active-low reset, clears the count
//   load      in  1        load load_val (has priority over en)
//   load_val  in  TIMER_W  value to load
//   en        in  1        decrement by one while nonzero
//   count     out TIMER_W  current count
//   zero      out 1        count == 0
module login_timer
    import mmu_login_ctrl_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               en,
    output logic [TIMER_W-1:0] count,
    output logic               zero
);

    function automatic logic [TIMER_W-1:0] sat_dec(input logic [TIMER_W-1:0] v);
        if (v == '0) begin
            return '0;
        end
        return v - 1'b1;
    endfunction

    logic [TIMER_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= sat_dec(cnt);
        end
    end

    assign count = cnt;
    assign zero  = (cnt == '0);

endmodule

// File: rtl/mmu_login_ctrl.sv
// mmu_login_ctrl
//   Session controller in front of the MMU. Snoops processor stores to
//   KEY_ADDR for the unlock sequence KEY0, KEY1, KEY2; on success holds
//   `login` high for a session. LOGOUT_KEY stored during a session ends it.
//   Wrong keys are counted; MAX_FAILS of them lock the controller out for
//   LOCKOUT_CYCLES cycles.
//   Optional feature macro: MMU_LOGIN_TIMEOUT_EN -- when defined, a session
//   expires after SESSION_CYCLES cycles; when undefined, a session has no
//   timeout and `timer` reads 0 while in SESSION.
// Ports:
//   clock            in  1   rising-edge clock
//   reset_n          in  1   synchronous active-low reset
//   proc2mem_command in  2   BUS_NONE / BUS_LOAD / BUS_STORE
//   proc2mem_addr    in  64  bus address
//   proc2mem_data    in  64  store data
//   login            out 1   high exactly while in SESSION (to MMU)
//   locked           out 1   high exactly while in LOCKOUT
//   fail_cnt         out 2   wrong keys since last success / lockout exit
//   timer            out 11  remaining SESSION / LOCKOUT cycles, else 0
module mmu_login_ctrl
    import mmu_login_ctrl_pkg::*;
#(
    parameter logic [63:0]     KEY_ADDR       = 64'd7992,
    parameter logic [63:0]     KEY0           = 64'h5a5a,
    parameter logic [63:0]     KEY1           = 64'h1234,
    parameter logic [63:0]     KEY2           = 64'hc0de,
    parameter logic [63:0]     LOGOUT_KEY     = 64'hdead,
    parameter int unsigned     SESSION_CYCLES = 1024,
    parameter logic [FAIL_W-1:0] MAX_FAILS    = 2'd3,
    parameter int unsigned     LOCKOUT_CYCLES = 256
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [1:0]         proc2mem_command,
    input  logic [63:0]        proc2mem_addr,
    input  logic [63:0]        proc2mem_data,
    output logic               login,
    output logic               locked,
    output logic [FAIL_W-1:0]  fail_cnt,
    output logic [TIMER_W-1:0] timer
);

    localparam logic [TIMER_W-1:0] SESSION_LOAD = TIMER_W'(SESSION_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);

    function automatic logic [FAIL_W-1:0] fail_sat_inc(input logic [FAIL_W-1:0] f);
        if (f >= MAX_FAILS) begin
            return MAX_FAILS;
        end
        return f + 1'b1;
    endfunction

    logic [2:0]          state, state_nxt;
    logic [FAIL_W-1:0]   fail_q, fail_nxt;
    logic                key_store;
    logic                fail_hit;
    logic                is_logout;
    logic [63:0]         expected_key;
    logic                tmr_load, tmr_en, tmr_zero;
    logic [TIMER_W-1:0]  tmr_load_val, tmr_count;

    // Loads and stores to other addresses are invisible to the FSM, so a
    // sequence in progress survives unrelated bus traffic.
    assign key_store = (proc2mem_command == BUS_STORE) && (proc2mem_addr == KEY_ADDR);
    assign is_logout = key_store && (proc2mem_data == LOGOUT_KEY);
    assign fail_hit  = ({1'b0, fail_q} + 1'b1) == {1'b0, MAX_FAILS};

    always_comb begin
        expected_key = KEY0;
        case (state)
            LOGIN_GOT0: expected_key = KEY1;
            LOGIN_GOT1: expected_key = KEY2;
            default:    expected_key = KEY0;
        endcase
    end

    login_timer u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= LOGIN_IDLE;
            fail_q <= '0;
        end else begin
            state  <= state_nxt;
            fail_q <= fail_nxt;
        end
    end

    // Next-state and timer control
    always_comb begin
        state_nxt    = state;
        fail_nxt     = fail_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;
        case (state)
            LOGIN_IDLE, LOGIN_GOT0, LOGIN_GOT1: begin
                if (key_store) begin
                    if (proc2mem_data == expected_key) begin
                        if (state == LOGIN_GOT1) begin
                            state_nxt = LOGIN_SESSION;
                            fail_nxt  = '0;
`ifdef MMU_LOGIN_TIMEOUT_EN
                            tmr_load     = 1'b1;
                            tmr_load_val = SESSION_LOAD;
`endif
                        end else if (state == LOGIN_GOT0) begin
                            state_nxt = LOGIN_GOT1;
                        end else begin
                            state_nxt = LOGIN_GOT0;
                        end
                    end else if (fail_hit) begin
                        state_nxt    = LOGIN_LOCKOUT;
                        fail_nxt     = MAX_FAILS;
                        tmr_load     = 1'b1;
                        tmr_load_val = LOCKOUT_LOAD;
                    end else begin
                        state_nxt = LOGIN_IDLE;
                        fail_nxt  = fail_sat_inc(fail_q);
                    end
                end
            end
            LOGIN_SESSION: begin
`ifdef MMU_LOGIN_TIMEOUT_EN
                // Logout and expiry in the same cycle both land in IDLE.
                if (is_logout || tmr_zero) begin
                    state_nxt = LOGIN_IDLE;
                    tmr_load  = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
`else
                if (is_logout) begin
                    state_nxt = LOGIN_IDLE;
                    tmr_load  = 1'b1;
                end
`endif
            end
            LOGIN_LOCKOUT: begin
                // Key stores are ignored; only the timer can end lockout.
                if (tmr_zero) begin
                    state_nxt = LOGIN_IDLE;
                    fail_nxt  = '0;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                state_nxt = LOGIN_IDLE;
                fail_nxt  = '0;
            end
        endcase
    end

`ifndef MMU_LOGIN_TIMEOUT_EN
    // The session length is only meaningful with the timeout built in.
    logic unused_session_cfg;
    assign unused_session_cfg = ^SESSION_LOAD;
`endif

    // Outputs, decoded from registered state only
    always_comb begin
        login    = (state == LOGIN_SESSION);
        locked   = (state == LOGIN_LOCKOUT);
        fail_cnt = fail_q;
        timer    = tmr_count;
    end

endmodule

// File: tb/tb_mmu_login_ctrl.sv
module tb_mmu_login_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic        login;
    logic        locked;
    logic [1:0]  fail_cnt;
    logic [10:0] timer;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mmu_login_ctrl #(
        .SESSION_CYCLES (16)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .proc2mem_command (proc2mem_command),
        .proc2mem_addr    (proc2mem_addr),
        .proc2mem_data    (proc2mem_data),
        .login            (login),
        .locked           (locked),
        .fail_cnt         (fail_cnt),
        .timer            (timer)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [1:0] cmd, input logic [63:0] addr, input logic [63:0] data);
        proc2mem_command = cmd;
        proc2mem_addr    = addr;
        proc2mem_data    = data;
        tick();
        proc2mem_command = 2'h0;
        proc2mem_addr    = 64'd0;
        proc2mem_data    = 64'd0;
    endtask

    task automatic key(input logic [63:0] data);
        bus(2'h2, 64'd7992, data);
    endtask

    task automatic load8100();
        bus(2'h1, 64'd8100, 64'h5a5a);
    endtask

    initial begin
        reset_n          = 1'b0;
        proc2mem_command = 2'h0;
        proc2mem_addr    = 64'd0;
        proc2mem_data    = 64'd0;
        tick();
        tick();
        chk("rst_login", 64'(login), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_fail", 64'(fail_cnt), 64'd0);
        chk("rst_timer", 64'(timer), 64'd0);
        reset_n = 1'b1;

        // Back-to-back correct sequence
        key(64'h5a5a);
        chk("got0_login", 64'(login), 64'd0);
        key(64'h1234);
        key(64'hc0de);
        chk("seq_login", 64'(login), 64'd1);
        chk("seq_fail", 64'(fail_cnt), 64'd0);
`ifdef MMU_LOGIN_TIMEOUT_EN
        chk("seq_timer", 64'(timer), 64'd15);
`else
        chk("seq_timer", 64'(timer), 64'd0);
`endif
        key(64'hdead);
        chk("logout1_login", 64'(login), 64'd0);
        chk("logout1_timer", 64'(timer), 64'd0);

        // Sequence with interleaved loads and a non-key store
        key(64'h5a5a);
        load8100();
        load8100();
        key(64'h1234);
        load8100();
        bus(2'h2, 64'd8100, 64'h0bad);
        load8100();
        load8100();
        bus(2'h1, 64'd7992, 64'h0bad);
        key(64'hc0de);
        chk("ilv_login", 64'(login), 64'd1);
        chk("ilv_fail", 64'(fail_cnt), 64'd0);
        key(64'hdead);
        chk("logout2_login", 64'(login), 64'd0);

        // Three wrong keys lead to lockout
        key(64'h0001);
        chk("fail1", 64'(fail_cnt), 64'd1);
        chk("fail1_locked", 64'(locked), 64'd0);
        key(64'h0001);
        chk("fail2", 64'(fail_cnt), 64'd2);
        key(64'h0001);
        chk("lock_locked", 64'(locked), 64'd1);
        chk("lock_fail", 64'(fail_cnt), 64'd3);
        chk("lock_timer", 64'(timer), 64'd255);
        key(64'h5a5a);
        key(64'h1234);
        key(64'hc0de);
        chk("lock_seq_login", 64'(login), 64'd0);
        chk("lock_seq_locked", 64'(locked), 64'd1);
        chk("lock_seq_timer", 64'(timer), 64'd252);
        repeat (252) tick();
        chk("lock_end_timer", 64'(timer), 64'd0);
        chk("lock_end_locked", 64'(locked), 64'd1);
        tick();
        chk("unlock_locked", 64'(locked), 64'd0);
        chk("unlock_fail", 64'(fail_cnt), 64'd0);

        // Wrong third key, then recovery
        key(64'h5a5a);
        key(64'h1234);
        key(64'hbeef);
        chk("bad3_login", 64'(login), 64'd0);
        chk("bad3_fail", 64'(fail_cnt), 64'd1);
        key(64'h5a5a);
        key(64'h1234);
        key(64'hc0de);
        chk("rec_login", 64'(login), 64'd1);
        chk("rec_fail", 64'(fail_cnt), 64'd0);

        // Wrong key during a session is ignored
        key(64'h0001);
        chk("sess_bad_login", 64'(login), 64'd1);
        chk("sess_bad_fail", 64'(fail_cnt), 64'd0);

`ifdef MMU_LOGIN_TIMEOUT_EN
        chk("to_timer14", 64'(timer), 64'd14);
        repeat (13) tick();
        chk("to_timer1", 64'(timer), 64'd1);
        tick();
        chk("to_last_login", 64'(login), 64'd1);
        chk("to_last_timer", 64'(timer), 64'd0);
        tick();
        chk("to_expired_login", 64'(login), 64'd0);
        key(64'h5a5a);
        key(64'h1234);
        key(64'hc0de);
        chk("relog_login", 64'(login), 64'd1);
`else
        repeat (2000) tick();
        chk("noto_login", 64'(login), 64'd1);
        chk("noto_timer", 64'(timer), 64'd0);
`endif

        // Reset in the middle of a session
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midrst_login", 64'(login), 64'd0);
        chk("midrst_timer", 64'(timer), 64'd0);
        chk("midrst_fail", 64'(fail_cnt), 64'd0);
        tick();
        chk("midrst_idle", 64'(login), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
